// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and default sizes for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam int DEF_DATABITS = 8;
  localparam int DEF_TBITS    = 8;
  localparam int DEF_TIMEOUT  = 255;

endpackage

// File: rtl/arb_stall_timer.sv
// rtl/arb_stall_timer.sv - counts consecutive owner-idle cycles and flags when the limit is reached
module arb_stall_timer
  import fifo_arb_pkg::*;
#(
  parameter int TBITS   = DEF_TBITS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TBITS-1:0] LIMIT = TBITS'(TIMEOUT);

  logic [TBITS-1:0] count;

  // Clear has priority; the count parks at LIMIT so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + TBITS'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - packet-locked round-robin arbiter for the shared FIFO write port
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATABITS = DEF_DATABITS,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int TBITS    = DEF_TBITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATABITS-1:0] s0_data,
  input  logic                s0_valid,
  input  logic                s0_last,
  output logic                s0_ready,
  input  logic [DATABITS-1:0] s1_data,
  input  logic                s1_valid,
  input  logic                s1_last,
  output logic                s1_ready,
  output logic [DATABITS-1:0] fifo_write_data,
  output logic                fifo_write_en,
  input  logic                fifo_full,
  output logic                owner,
  output logic                busy,
  output logic                timeout_err
);

  arb_state_t state, state_nxt;
  logic       last_served, last_served_nxt;
  logic       owner_nxt;
  logic       own0, own1, owning;
  logic       cur_valid, cur_last;
  logic       port_open, beat;
  logic       expired;

  assign own0   = (state == ST_OWN0);
  assign own1   = (state == ST_OWN1);
  assign owning = own0 || own1;

  assign cur_valid = (own0 && s0_valid) || (own1 && s1_valid);
  assign cur_last  = (own0 && s0_last)  || (own1 && s1_last);

  // The port is open to the owner whenever the FIFO has room; it is shut in
  // the expiry cycle so a late beat cannot race the revocation, and in reset.
  assign port_open = owning && !fifo_full && !expired && !rst;
  assign beat      = cur_valid && port_open;

  assign s0_ready        = own0 && port_open;
  assign s1_ready        = own1 && port_open;
  assign fifo_write_en   = beat;
  assign fifo_write_data = own0 ? s0_data : (own1 ? s1_data : '0);
  assign busy            = (state != ST_IDLE);
  assign timeout_err     = owning && expired && !rst;

  // Backpressure holds the count; only an owner that is free to send but
  // does not is treated as stalled.
  arb_stall_timer #(
    .TBITS   (TBITS),
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!owning || beat || expired),
    .enable  (owning && !cur_valid && !fifo_full),
    .expired (expired)
  );

  // Next-state: grant from IDLE, hand off on a last beat, revoke on stall.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    owner_nxt       = owner;
    case (state)
      ST_IDLE: begin
        if (s0_valid && (!s1_valid || last_served)) begin
          state_nxt = ST_OWN0;
          owner_nxt = 1'b0;
        end else if (s1_valid) begin
          state_nxt = ST_OWN1;
          owner_nxt = 1'b1;
        end
      end
      ST_OWN0: begin
        if (beat && cur_last) begin
          last_served_nxt = 1'b0;
          if (s1_valid) begin
            state_nxt = ST_OWN1;
            owner_nxt = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (expired) begin
          last_served_nxt = 1'b0;
          state_nxt       = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (beat && cur_last) begin
          last_served_nxt = 1'b1;
          if (s0_valid) begin
            state_nxt = ST_OWN0;
            owner_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (expired) begin
          last_served_nxt = 1'b1;
          state_nxt       = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, round-robin pointer and owner index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_served <= 1'b1;
      owner       <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      owner       <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for the FIFO write arbiter
module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s0_data, s1_data;
  logic       s0_valid, s0_last, s0_ready;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] fifo_write_data;
  logic       fifo_write_en, fifo_full;
  logic       owner, busy, timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int win_first = -1;
  int win_last = -1;
  int to_count = 0;
  int to_cyc = -1;
  logic to_prev = 1'b0;
  logic busy_after_to = 1'b1;
  logic [7:0] sb[$];

  fifo_write_arbiter #(
    .DATABITS (8),
    .TIMEOUT  (4),
    .TBITS    (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s0_data         (s0_data),
    .s0_valid        (s0_valid),
    .s0_last         (s0_last),
    .s0_ready        (s0_ready),
    .s1_data         (s1_data),
    .s1_valid        (s1_valid),
    .s1_last         (s1_last),
    .s1_ready        (s1_ready),
    .fifo_write_data (fifo_write_data),
    .fifo_write_en   (fifo_write_en),
    .fifo_full       (fifo_full),
    .owner           (owner),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (fifo_write_en) begin
      check("wr_while_full", 32'(fifo_full), 32'd0);
      check("sb_underflow", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("fifo_data", 32'(fifo_write_data), 32'(sb.pop_front()));
      if (win_first < 0) win_first = cyc;
      win_last = cyc;
      wr_count++;
    end
    if (to_prev) busy_after_to = busy;
    if (timeout_err) begin
      to_count++;
      to_cyc = cyc;
    end
    to_prev = timeout_err;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    s0_data = '0; s0_valid = 1'b0; s0_last = 1'b0;
    s1_data = '0; s1_valid = 1'b0; s1_last = 1'b0;
    fifo_full = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input bit which);
    int g = 0;
    @(negedge clk);
    while (!(which ? s1_ready : s0_ready) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(which ? "s1_handshake" : "s0_handshake", 32'(which ? s1_ready : s0_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [63:0] beats, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      s0_data = beats[8*i +: 8];
      s0_valid = 1'b1;
      s0_last = with_last && (i == n - 1);
      wait_ready(1'b0);
    end
    s0_valid = 1'b0; s0_last = 1'b0; s0_data = '0;
  endtask

  task automatic send1(input logic [63:0] beats, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      s1_data = beats[8*i +: 8];
      s1_valid = 1'b1;
      s1_last = with_last && (i == n - 1);
      wait_ready(1'b1);
    end
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int base;
    int to_base;
    int stall_cyc;

    // Reset state
    step(1);
    do_reset();
    @(negedge clk);
    check("rst_s0_ready", 32'(s0_ready), 32'd0);
    check("rst_s1_ready", 32'(s1_ready), 32'd0);
    check("rst_write_en", 32'(fifo_write_en), 32'd0);
    check("rst_write_data", 32'(fifo_write_data), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    step(1);

    // Contention straight out of reset: s0 wins the first tie, handoffs back-to-back
    to_base = to_count;
    win_first = -1;
    sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'hB0); sb.push_back(8'hB1);
    sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'hB0); sb.push_back(8'hB1);
    fork
      begin send0(64'hA1A0, 2, 1'b1); send0(64'hA1A0, 2, 1'b1); end
      begin send1(64'hB1B0, 2, 1'b1); send1(64'hB1B0, 2, 1'b1); end
    join
    check("rr_span", 32'(win_last - win_first), 32'd7);
    check("rr_no_timeout", 32'(to_count - to_base), 32'd0);
    step(1);
    check("rr_idle_busy", 32'(busy), 32'd0);

    // Single producer, four beats
    do_reset();
    win_first = -1;
    base = wr_count;
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33); sb.push_back(8'h44);
    v = cyc;
    send0(64'h44332211, 4, 1'b1);
    check("single_latency", 32'(win_first - v), 32'd1);
    check("single_span", 32'(win_last - win_first), 32'd3);
    check("single_count", 32'(wr_count - base), 32'd4);
    check("single_busy", 32'(busy), 32'd0);
    check("single_owner", 32'(owner), 32'd0);

    // Backpressure for three cycles in the middle of a five-beat s1 packet
    do_reset();
    win_first = -1;
    base = wr_count;
    to_base = to_count;
    for (int i = 0; i < 5; i++) sb.push_back(8'hB0 + 8'(i));
    fork
      send1(64'h000000B4B3B2B1B0, 5, 1'b1);
      begin
        int g = 0;
        while (wr_count < base + 2 && g < 100) begin
          @(posedge clk);
          g++;
        end
        #1;
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_s1_ready", 32'(s1_ready), 32'd0);
          check("bp_write_en", 32'(fifo_write_en), 32'd0);
          @(posedge clk);
          #1;
        end
        fifo_full = 1'b0;
      end
    join
    check("bp_count", 32'(wr_count - base), 32'd5);
    check("bp_span", 32'(win_last - win_first), 32'd7);
    check("bp_no_timeout", 32'(to_count - to_base), 32'd0);
    check("bp_owner", 32'(owner), 32'd1);

    // Stall timeout: s0 stops mid-packet while s1 waits
    do_reset();
    to_base = to_count;
    sb.push_back(8'h5A);
    send0(64'h5A, 1, 1'b0);
    stall_cyc = win_last;
    win_first = -1;
    sb.push_back(8'h6B); sb.push_back(8'h6C);
    send1(64'h6C6B, 2, 1'b1);
    check("to_pulses", 32'(to_count - to_base), 32'd1);
    check("to_delay", 32'(to_cyc - stall_cyc), 32'd5);
    check("to_idle_after", 32'(busy_after_to), 32'd0);
    check("to_s1_grant_cycle", 32'(win_first - to_cyc), 32'd2);
    check("to_owner", 32'(owner), 32'd1);

    // Reset on beat 2 of an s0 packet
    do_reset();
    sb.push_back(8'hC0);
    s0_data = 8'hC0; s0_valid = 1'b1; s0_last = 1'b0;
    wait_ready(1'b0);
    s0_data = 8'hC1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_write_en", 32'(fifo_write_en), 32'd0);
    check("mid_rst_s0_ready", 32'(s0_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s0_valid = 1'b0; s0_data = '0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_owner", 32'(owner), 32'd0);
    check("post_rst_data", 32'(fifo_write_data), 32'd0);
    check("post_rst_readies", 32'({s0_ready, s1_ready}), 32'd0);
    check("post_rst_timeout", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;
    sb.push_back(8'hD0);
    send1(64'hD0, 1, 1'b1);
    check("post_rst_s1_owner", 32'(owner), 32'd1);
    sb.push_back(8'hE0); sb.push_back(8'hF0);
    fork
      send0(64'hE0, 1, 1'b1);
      send1(64'hF0, 1, 1'b1);
    join
    check("tie_last_owner", 32'(owner), 32'd1);

    step(3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Shares the single write port of the pixel/command FIFO between two producers, for example the column renderer and the command/SPI loader. Arbitration is round-robin and locked per packet. A granted producer keeps the port until it sends the beat marked last, so packets never interleave in the FIFO. A stall timer releases a grant when its producer stops sending mid-packet. The block sits directly in front of the FIFO write side and drives its write_en and write_data.

Parameters:
DATABITS, 8, width of a data beat (matches the FIFO data width)
TIMEOUT, 255, number of consecutive owner-idle cycles after which the grant is revoked (1..2^TBITS-1)
TBITS, 8, width of the stall counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
s0_data  in  DATABITS  producer 0 beat
s0_valid  in  1  producer 0 beat available
s0_last  in  1  producer 0 beat is the final beat of its packet
s0_ready  out  1  producer 0 beat accepted this cycle when high together with s0_valid
s1_data  in  DATABITS  producer 1 beat
s1_valid  in  1  producer 1 beat available
s1_last  in  1  producer 1 beat is the final beat of its packet
s1_ready  out  1  producer 1 accept
fifo_write_data  out  DATABITS  data driven to the FIFO write port
fifo_write_en  out  1  FIFO write strobe
fifo_full  in  1  registered full flag from the FIFO
owner  out  1  index of the current/last grant holder
busy  out  1  high while a grant is held
timeout_err  out  1  one-cycle pulse when a grant is revoked by the stall timer

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values:
  - state IDLE; s0_ready = s1_ready = 0; fifo_write_en = 0; fifo_write_data = 0.
  - owner = 0, busy = 0, timeout_err = 0, stall counter = 0.
  - last_served = 1, so producer 0 wins the first tie.
- States: IDLE, OWN0, OWN1, held in a registered state variable. busy = (state != IDLE).
- IDLE:
  - No ready is asserted.
  - If only one valid is high, go to that producer's OWN state.
  - If both are high, grant the producer not equal to last_served.
  - Grant is registered, so first acceptance happens at the earliest one cycle after valid is seen.
- OWNn readiness:
  - sn_ready = !fifo_full. It must not depend on sn_valid.
  - The other producer's ready = 0.
- OWNn beat:
  - beat = sn_valid & sn_ready.
  - fifo_write_en = beat, driven combinationally in the same cycle.
  - fifo_write_data = sn_data while in OWNn, else 0.
  - fifo_write_en is never high while fifo_full is high; the FIFO's simultaneous read/write path does not check full.
- OWNn on a beat with sn_last:
  - Set last_served = n.
  - If the other producer's valid is high this cycle, go directly to OWN(other), with no idle bubble.
  - Otherwise go to IDLE.
- OWNn, non-last beat: remain in OWNn and clear the stall counter.
- Stall timer:
  - In OWNn with sn_valid = 0 and fifo_full = 0, the counter increments.
  - A beat or entry into an OWN state clears it.
  - While fifo_full = 1 the counter holds; backpressure is not a producer stall.
  - When the counter reaches TIMEOUT:
    - Go to IDLE and set last_served = n.
    - Pulse timeout_err for exactly one cycle and clear the counter.
  - The partial packet already in the FIFO is not removed; downstream resynchronises on its own framing.
- owner is updated on every grant and holds its value in IDLE.
- Throughput: with the FIFO not full, one beat per cycle for the duration of a packet.
- Reset asserted mid-packet: return to IDLE on the next edge with all reset values. Any beat presented in the reset cycle is not written (fifo_write_en forced 0 while rst is high).
- Counter width rule: TIMEOUT < 2^TBITS. The comparison is equality on a TBITS-wide counter, with no wrap.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_OWN0 = 2'd1, ST_OWN1 = 2'd2;
  - default DATABITS/TBITS/TIMEOUT constants.
- One natural sub-module, arb_stall_timer. Inputs: clk, rst, clear, enable. Output: expired, asserted when the count equals TIMEOUT. It is parameterised by TBITS and TIMEOUT.
- The rest is a single always-comb next-state block plus one registered block.

Test Plan:
- Single producer, no contention:
  - Stimulus: s0 sends a 4-beat packet 0x11, 0x22, 0x33, 0x44(last) with fifo_full = 0.
  - Response: fifo_write_en high for 4 consecutive cycles starting one cycle after s0_valid; FIFO contents 0x11..0x44 in order; then IDLE, busy = 0.
- Contention and round-robin:
  - Stimulus: both producers valid from reset, each sending 2-beat packets (s0: 0xA0, 0xA1; s1: 0xB0, 0xB1), repeated twice.
  - Response: FIFO order A0 A1 B0 B1 A0 A1 B0 B1; handoffs occur with no idle cycle between packets.
- Backpressure:
  - Stimulus: fifo_full forced high for 3 cycles in the middle of a 5-beat s1 packet.
  - Response: s1_ready = 0 and fifo_write_en = 0 during those 3 cycles; no timeout_err; all 5 beats written in order after release.
- Stall timeout:
  - Setup: TIMEOUT = 4.
  - Stimulus: s0 sends 1 beat without last, then drops valid; s1 becomes valid meanwhile.
  - Response: timeout_err pulses once, 4 idle cycles after the last beat; state passes through IDLE; s1 is granted next.
- Reset mid-packet:
  - Stimulus: rst asserted for 1 cycle on beat 2 of a 4-beat s0 packet.
  - Response: fifo_write_en = 0 in the reset cycle; all outputs at reset values; a subsequent s1 request is granted normally, and s0 wins a later tie because last_served = 1.
